// File: rtl/mips_pkg.sv
// Shared encodings for the writeback stage: load types, destination selects
// and the late-result starvation FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_LINK = 2'b10;

  localparam logic [4:0] LINK_REG = 5'd31;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FORCE = 2'b10
  } wb_state_e;

endpackage

// File: rtl/writeback_module_if.sv
// MEM/WB pipeline inputs, late-result handshake and register-file write port.
interface writeback_module_if;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        reg_write_in;
  logic        mem_to_reg;
  logic [1:0]  reg_dst;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [2:0]  load_type;
  logic [31:0] alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] next_pc;
  logic        late_valid;
  logic [4:0]  late_reg;
  logic [31:0] late_data;
  logic        late_ready;
  logic        stall_req;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  modport master (
    output in_valid, stall, flush, reg_write_in, mem_to_reg, reg_dst, rt, rd,
           load_type, alu_result, mem_read_data, next_pc,
           late_valid, late_reg, late_data,
    input  late_ready, stall_req, reg_write, write_reg, write_data
  );

  modport slave (
    input  in_valid, stall, flush, reg_write_in, mem_to_reg, reg_dst, rt, rd,
           load_type, alu_result, mem_read_data, next_pc,
           late_valid, late_reg, late_data,
    output late_ready, stall_req, reg_write, write_reg, write_data
  );
endinterface

// File: rtl/writeback_module_load_align.sv
// Big-endian byte/half extraction and sign/zero extension of a loaded word.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_mem_data,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_load_type,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_mem_data[31:24];
    case (i_offset)
      2'd0: w_byte = i_mem_data[31:24];
      2'd1: w_byte = i_mem_data[23:16];
      2'd2: w_byte = i_mem_data[15:8];
      2'd3: w_byte = i_mem_data[7:0];
      default: w_byte = i_mem_data[31:24];
    endcase
  end

  // Halfword offset bit 0 is ignored; misalignment is trapped upstream.
  assign w_half = i_offset[1] ? i_mem_data[15:0] : i_mem_data[31:16];

  always_comb begin
    o_data = i_mem_data;
    case (i_load_type)
      LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {24'b0, w_byte};
      LT_LH:   o_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_data = {16'b0, w_half};
      default: o_data = i_mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_module.sv
// MIPS writeback stage: selects the write value and arbitrates the single
// register-file write port between the pipeline and late mul/div results.
module writeback_module
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset_n,
  writeback_module_if.slave wb
);

  wb_state_e   r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_reg_write;
  logic [4:0]  r_write_reg;
  logic [31:0] r_write_data;

  logic        w_pipe_claim;
  logic        w_late_grant;
  logic        w_grant;
  logic [4:0]  w_pipe_dest;
  logic [31:0] w_pipe_data;
  logic [31:0] w_load_data;
  logic [4:0]  w_sel_dest;
  logic [31:0] w_sel_data;
  logic        w_do_write;

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == 5'h1F) ? c : c + 5'd1;
  endfunction

  load_align u_align (
    .i_mem_data  (wb.mem_read_data),
    .i_offset    (wb.alu_result[1:0]),
    .i_load_type (wb.load_type),
    .o_data      (w_load_data)
  );

  // While the FSM forces a yield the pipeline input is ignored outright.
  assign w_pipe_claim = wb.in_valid & wb.reg_write_in & ~wb.stall & ~wb.flush
                        & (r_state != ST_FORCE);
  assign w_late_grant = reset_n & wb.late_valid & ~w_pipe_claim;
  assign w_grant      = w_pipe_claim | w_late_grant;

  always_comb begin
    case (wb.reg_dst)
      RD_RD:   w_pipe_dest = wb.rd;
      RD_LINK: w_pipe_dest = LINK_REG;
      default: w_pipe_dest = wb.rt;
    endcase
  end

  assign w_pipe_data = (wb.reg_dst == RD_LINK) ? wb.next_pc :
                       (wb.mem_to_reg ? w_load_data : wb.alu_result);

  assign w_sel_dest = w_pipe_claim ? w_pipe_dest : wb.late_reg;
  assign w_sel_data = w_pipe_claim ? w_pipe_data : wb.late_data;
  assign w_do_write = w_grant & (w_sel_dest != ZERO_REG);

  // Write port register stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      r_reg_write <= w_do_write;
      if (w_do_write) begin
        r_write_reg  <= w_sel_dest;
        r_write_data <= w_sel_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (wb.late_valid && !w_late_grant) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 5'd1;
        end
      end
      ST_WAIT: begin
        if (w_late_grant || !wb.late_valid) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 5'd0;
        end else if (int'(r_cnt) >= STARVE_LIMIT - 1) begin
          w_state_nxt = ST_FORCE;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_FORCE: begin
        if (w_late_grant || !wb.late_valid) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 5'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign wb.late_ready = w_late_grant;
  assign wb.stall_req  = (r_state == ST_FORCE);
  assign wb.reg_write  = r_reg_write;
  assign wb.write_reg  = r_write_reg;
  assign wb.write_data = r_write_data;

endmodule
